// File: rtl/eq_lock_tracker_pkg.sv
// Shared definitions for the equality lock tracker: FSM encodings and run counter width.
package eq_lock_tracker_pkg;

  localparam int unsigned RUN_W = 8;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

endpackage : eq_lock_tracker_pkg

// File: rtl/eq_lock_tracker_if.sv
// Sample/status bundle between the comparator side (master) and the lock tracker (slave).
interface eq_lock_tracker_if
  import eq_lock_tracker_pkg::*;
#(
  parameter int unsigned CNT_W = 8
);

  logic             eq_in;
  logic             eq_valid;
  logic             clear;
  logic             locked;
  logic             lock_pulse;
  logic             lost_pulse;
  logic [RUN_W-1:0] run_cnt;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] mismatch_cnt;

  modport master (
    output eq_in, eq_valid, clear,
    input  locked, lock_pulse, lost_pulse, run_cnt, match_cnt, mismatch_cnt
  );

  modport slave (
    input  eq_in, eq_valid, clear,
    output locked, lock_pulse, lost_pulse, run_cnt, match_cnt, mismatch_cnt
  );

endinterface : eq_lock_tracker_if

// File: rtl/eq_lock_tracker_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clr has priority over inc.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule : sat_counter

// File: rtl/eq_lock_tracker.sv
// Lock/unlock tracker for the 2-bit comparator's equality result, with saturating totals.
// Define EQ_LOCK_SYNC_EN to insert a two-flop synchronizer on the sample inputs.
module eq_lock_tracker
  import eq_lock_tracker_pkg::*;
#(
  parameter int unsigned LOCK_COUNT   = 4,
  parameter int unsigned UNLOCK_COUNT = 2,
  parameter int unsigned CNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  eq_lock_tracker_if.slave  bus
);

  if ((LOCK_COUNT == 0) || (LOCK_COUNT > 255)) begin : g_bad_lock_count
    $error("eq_lock_tracker: LOCK_COUNT must be in 1..255");
  end
  if ((UNLOCK_COUNT == 0) || (UNLOCK_COUNT > 255)) begin : g_bad_unlock_count
    $error("eq_lock_tracker: UNLOCK_COUNT must be in 1..255");
  end

  localparam logic [RUN_W-1:0] LOCK_LAST   = RUN_W'(LOCK_COUNT - 1);
  localparam logic [RUN_W-1:0] UNLOCK_LAST = RUN_W'(UNLOCK_COUNT - 1);

  logic eq_s;
  logic vld_s;
  logic clr_s;

`ifdef EQ_LOCK_SYNC_EN
  // clear rides the same pipe so it stays aligned with the sample it accompanies
  logic [1:0] eq_sync_q;
  logic [1:0] vld_sync_q;
  logic [1:0] clr_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eq_sync_q  <= '0;
      vld_sync_q <= '0;
      clr_sync_q <= '0;
    end else begin
      eq_sync_q  <= {eq_sync_q[0], bus.eq_in};
      vld_sync_q <= {vld_sync_q[0], bus.eq_valid};
      clr_sync_q <= {clr_sync_q[0], bus.clear};
    end
  end

  assign eq_s  = eq_sync_q[1];
  assign vld_s = vld_sync_q[1];
  assign clr_s = clr_sync_q[1];
`else
  assign eq_s  = bus.eq_in;
  assign vld_s = bus.eq_valid;
  assign clr_s = bus.clear;
`endif

  state_e           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             lock_pulse_q, lock_pulse_d;
  logic             lost_pulse_q, lost_pulse_d;

  // Next state: run_cnt counts matches in SEARCH and mismatches in LOCKED
  always_comb begin
    state_d      = state_q;
    run_d        = run_q;
    lock_pulse_d = 1'b0;
    lost_pulse_d = 1'b0;
    if (clr_s) begin
      state_d = ST_SEARCH;
      run_d   = '0;
    end else if (vld_s) begin
      unique case (state_q)
        ST_SEARCH: begin
          if (!eq_s) begin
            run_d = '0;
          end else if (run_q == LOCK_LAST) begin
            state_d      = ST_LOCKED;
            run_d        = '0;
            lock_pulse_d = 1'b1;
          end else begin
            run_d = run_q + RUN_W'(1);
          end
        end
        ST_LOCKED: begin
          if (eq_s) begin
            run_d = '0;
          end else if (run_q == UNLOCK_LAST) begin
            state_d      = ST_SEARCH;
            run_d        = '0;
            lost_pulse_d = 1'b1;
          end else begin
            run_d = run_q + RUN_W'(1);
          end
        end
        default: begin
          state_d = ST_SEARCH;
          run_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_SEARCH;
      run_q        <= '0;
      lock_pulse_q <= 1'b0;
      lost_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      lock_pulse_q <= lock_pulse_d;
      lost_pulse_q <= lost_pulse_d;
    end
  end

  logic [CNT_W-1:0] match_q;
  logic [CNT_W-1:0] mismatch_q;

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_s),
    .inc   (vld_s & eq_s),
    .q     (match_q)
  );

  sat_counter #(.W(CNT_W)) u_mismatch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_s),
    .inc   (vld_s & ~eq_s),
    .q     (mismatch_q)
  );

  assign bus.locked       = (state_q == ST_LOCKED);
  assign bus.lock_pulse   = lock_pulse_q;
  assign bus.lost_pulse   = lost_pulse_q;
  assign bus.run_cnt      = run_q;
  assign bus.match_cnt    = match_q;
  assign bus.mismatch_cnt = mismatch_q;

endmodule : eq_lock_tracker

// File: tb/tb_eq_lock_tracker.sv
// Scoreboard bench for eq_lock_tracker (LOCK_COUNT=4, UNLOCK_COUNT=2, CNT_W=3).
module tb_eq_lock_tracker;

`ifdef EQ_LOCK_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic       lk;
    logic       lp;
    logic       sp;
    logic [7:0] run;
    logic [2:0] mc;
    logic [2:0] mm;
  } snap_t;

  typedef struct packed {
    logic  chk;
    int    id;
    snap_t s;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   row_id = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  eq_lock_tracker_if #(.CNT_W(3)) bus ();

  eq_lock_tracker #(
    .LOCK_COUNT   (4),
    .UNLOCK_COUNT (2),
    .CNT_W        (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic snap_t sample_dut();
    snap_t a;
    a.lk  = bus.locked;
    a.lp  = bus.lock_pulse;
    a.sp  = bus.lost_pulse;
    a.run = bus.run_cnt;
    a.mc  = bus.match_cnt;
    a.mm  = bus.mismatch_cnt;
    return a;
  endfunction

  task automatic report(input string name, input int id, input snap_t act, input snap_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s #%0d: got lk=%b lp=%b sp=%b run=%0d mc=%0d mm=%0d, want lk=%b lp=%b sp=%b run=%0d mc=%0d mm=%0d",
               name, id, act.lk, act.lp, act.sp, act.run, act.mc, act.mm,
               exp.lk, exp.lp, exp.sp, exp.run, exp.mc, exp.mm);
    end
  endtask

  // Monitor: one response per edge, matched against the sample issued LAT edges earlier
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (rst_n && (sb_q.size() >= LAT)) begin
        e = sb_q.pop_front();
        if (e.chk) report("row", e.id, sample_dut(), e.s);
      end
    end
  end

  task automatic issue(input logic clr, input logic vld, input logic eq, input logic chk,
                       input logic lk, input logic lp, input logic sp,
                       input int run, input int mc, input int mm);
    exp_t e;
    @(negedge clk);
    bus.clear    = clr;
    bus.eq_valid = vld;
    bus.eq_in    = eq;
    row_id++;
    e.chk   = chk;
    e.id    = row_id;
    e.s.lk  = lk;
    e.s.lp  = lp;
    e.s.sp  = sp;
    e.s.run = 8'(run);
    e.s.mc  = 3'(mc);
    e.s.mm  = 3'(mm);
    sb_q.push_back(e);
  endtask

  // Idle padding so every checked row reaches the monitor; padding rows are not compared
  task automatic drain();
    for (int i = 0; i < LAT - 1; i++) issue(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_zero(input string name);
    snap_t z;
    z = '0;
    report(name, row_id, sample_dut(), z);
  endtask

  initial begin
    bus.eq_in    = 1'b0;
    bus.eq_valid = 1'b0;
    bus.clear    = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst_n = 1'b1;

    // three matches, then reset mid-run
    issue(0, 1, 1, 1, 0, 0, 0, 1, 1, 0);
    issue(0, 1, 1, 1, 0, 0, 0, 2, 2, 0);
    issue(0, 1, 1, 1, 0, 0, 0, 3, 3, 0);
    drain();
    @(negedge clk);
    bus.eq_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero("reset_midrun");
    sb_q.delete();
    @(negedge clk);
    check_zero("reset_held");
    rst_n = 1'b1;

    // four fresh matches are required to lock; pulse lasts one cycle
    issue(0, 1, 1, 1, 0, 0, 0, 1, 1, 0);
    issue(0, 1, 1, 1, 0, 0, 0, 2, 2, 0);
    issue(0, 1, 1, 1, 0, 0, 0, 3, 3, 0);
    issue(0, 1, 1, 1, 1, 1, 0, 0, 4, 0);
    issue(0, 0, 0, 1, 1, 0, 0, 0, 4, 0);

    // unlock: 0,1,0,0 -- lone mismatch is forgiven, the pair unlocks
    issue(0, 1, 0, 1, 1, 0, 0, 1, 4, 1);
    issue(0, 1, 1, 1, 1, 0, 0, 0, 5, 1);
    issue(0, 1, 0, 1, 1, 0, 0, 1, 5, 2);
    issue(0, 1, 0, 1, 0, 0, 1, 0, 5, 3);
    issue(0, 0, 0, 1, 0, 0, 0, 0, 5, 3);

    // eq_in toggling without qualifier changes nothing
    for (int i = 0; i < 10; i++) issue(0, 0, 1'(i % 2), 1, 0, 0, 0, 0, 5, 3);

    // clear wins over a valid sample
    issue(1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    issue(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    // break and resume: 1,1,1,0,1,1,1,1 locks only on the 8th
    issue(0, 1, 1, 1, 0, 0, 0, 1, 1, 0);
    issue(0, 1, 1, 1, 0, 0, 0, 2, 2, 0);
    issue(0, 1, 1, 1, 0, 0, 0, 3, 3, 0);
    issue(0, 1, 0, 1, 0, 0, 0, 0, 3, 1);
    issue(0, 1, 1, 1, 0, 0, 0, 1, 4, 1);
    issue(0, 1, 1, 1, 0, 0, 0, 2, 5, 1);
    issue(0, 1, 1, 1, 0, 0, 0, 3, 6, 1);
    issue(0, 1, 1, 1, 1, 1, 0, 0, 7, 1);
    issue(0, 0, 0, 1, 1, 0, 0, 0, 7, 1);
    issue(0, 1, 1, 1, 1, 0, 0, 0, 7, 1);
    issue(0, 1, 1, 1, 1, 0, 0, 0, 7, 1);

    // clear out of LOCKED emits no lost pulse
    issue(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    // ten matches: match total saturates at 7
    issue(0, 1, 1, 1, 0, 0, 0, 1, 1, 0);
    issue(0, 1, 1, 1, 0, 0, 0, 2, 2, 0);
    issue(0, 1, 1, 1, 0, 0, 0, 3, 3, 0);
    issue(0, 1, 1, 1, 1, 1, 0, 0, 4, 0);
    issue(0, 1, 1, 1, 1, 0, 0, 0, 5, 0);
    issue(0, 1, 1, 1, 1, 0, 0, 0, 6, 0);
    issue(0, 1, 1, 1, 1, 0, 0, 0, 7, 0);
    issue(0, 1, 1, 1, 1, 0, 0, 0, 7, 0);
    issue(0, 1, 1, 1, 1, 0, 0, 0, 7, 0);
    issue(0, 1, 1, 1, 1, 0, 0, 0, 7, 0);
    issue(0, 0, 0, 1, 1, 0, 0, 0, 7, 0);

    drain();
    repeat (3) @(negedge clk);
    if (sb_q.size() > LAT - 1) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want at most %0d", sb_q.size(), LAT - 1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_eq_lock_tracker

// File: doc/eq_lock_tracker.md
Name: eq_lock_tracker

Overview:
- Sequential stage directly downstream of the 2-bit equality comparator; consumes its single-bit equality result (AyB) once per qualified sample.
- Declares "lock" after LOCK_COUNT consecutive equal samples and declares "lock lost" after UNLOCK_COUNT consecutive unequal samples.
- Keeps saturating totals of matches and mismatches for display on workshop LEDs / 7-segment.

Parameters:
- LOCK_COUNT, 4: consecutive matches needed to enter LOCKED; legal range 1..255.
- UNLOCK_COUNT, 2: consecutive mismatches needed to leave LOCKED; legal range 1..255.
- CNT_W, 8: width of the match and mismatch total counters.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- eq_in  input  1  equality result from comparator; 1 = A equals B.
- eq_valid  input  1  sample qualifier; eq_in is consumed only when this is 1.
- clear  input  1  synchronous clear; same effect as reset.
- locked  output  1  1 while the FSM is in LOCKED.
- lock_pulse  output  1  one-cycle pulse on SEARCH->LOCKED.
- lost_pulse  output  1  one-cycle pulse on LOCKED->SEARCH.
- run_cnt  output  8  current consecutive-run counter.
- match_cnt  output  CNT_W  total accepted samples with eq=1, saturating.
- mismatch_cnt  output  CNT_W  total accepted samples with eq=0, saturating.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. While rst_n=0, all outputs are 0, the state is SEARCH and run_cnt=0.
- Outputs: all registered. The effect of a sample accepted at edge N is visible after edge N.
- clear: synchronous, priority over eq_valid. On the next edge it restores the reset state. No pulse is emitted, even when clearing out of LOCKED.
- Idle: when eq_valid=0, state and counters hold; lock_pulse and lost_pulse are 0.
- SEARCH, accepted eq=1:
  - if run_cnt+1 == LOCK_COUNT: go to LOCKED, run_cnt=0, lock_pulse=1;
  - else run_cnt increments.
- SEARCH, accepted eq=0: run_cnt=0.
- LOCKED, accepted eq=0:
  - if run_cnt+1 == UNLOCK_COUNT: go to SEARCH, run_cnt=0, lost_pulse=1;
  - else run_cnt increments.
- LOCKED, accepted eq=1: run_cnt=0, so only consecutive mismatches count toward unlock.
- Totals: every accepted sample increments match_cnt (eq=1) or mismatch_cnt (eq=0). Each counter saturates at 2^CNT_W-1 and never wraps. Totals update independently of FSM transitions.
- LOCK_COUNT=1: the first accepted match locks. UNLOCK_COUNT=1: the first accepted mismatch unlocks.
- Pulses: lock_pulse and lost_pulse are never both 1. Each is high exactly one cycle.
- Reset mid-run: asserting rst_n=0 during any state immediately zeroes all outputs, including an in-flight pulse.
- Parameter check: elaboration fails if LOCK_COUNT or UNLOCK_COUNT is 0 or exceeds 255.

Optional Feature:
- Macro: EQ_LOCK_SYNC_EN.
- Defined: eq_in and eq_valid pass through a two-flop synchronizer before use; this adds 2 cycles of latency to every response. Synchronizer flops reset to 0 with rst_n.
- Not defined: inputs are used directly, because the comparator is synchronous to clk. Latency is 1 edge.

Decomposition:
- Shared package/header eq_lock_defs:
  - state encodings ST_SEARCH=1'b0, ST_LOCKED=1'b1;
  - run counter width constant RUN_W=8.
- Sub-module sat_counter: parameter W; ports clk, rst_n, clr, inc, q.
  - Instanced twice, for match_cnt and mismatch_cnt.
- The FSM and run counter stay in the top module.

Test Plan:
- Reset value check: rst_n=0 mid-stream after 3 matches -> all outputs 0 immediately; after release, 4 matches are needed again for lock.
- Lock and hold: LOCK_COUNT=4, four valid eq=1 samples -> lock_pulse high one cycle after the 4th edge, locked=1, run_cnt=0, match_cnt=4.
- Break and resume: pattern 1,1,1,0,1,1,1,1 with valid=1 -> lock only after the 8th sample; mismatch_cnt=1, match_cnt=7.
- Unlock rules: locked, UNLOCK_COUNT=2, samples 0,1,0,0 -> lost_pulse after the 4th sample, locked=0; the lone 0 followed by 1 does not unlock.
- Qualifier and clear: eq_in toggling with eq_valid=0 for 10 cycles -> no change; clear=1 together with eq_valid=1 -> reset state, counters unchanged by that sample, no pulse.
- Saturation, CNT_W=3: 10 matches -> match_cnt=7 and holds at 7. Rerun with EQ_LOCK_SYNC_EN defined -> every response appears 2 cycles later.
